frame_buf_sched: RTL

Triple-buffer scheduler between a frame writer (test-pattern or sensor path) and a frame reader (display/DMA). Owns three DDR buffer base addresses, hands the writer a stable base address per frame with a field-reset pulse, promotes only complete frames to "ready", and lets the reader atomically take the newest complete frame on request. It replaces fixed two-buffer ping-pong toggling upstream of the DDR write/read ports.

---
 rtl/frame_buf_sched_pkg.sv | 20 ++
 rtl/frame_buf_sched_if.sv | 38 +++
 rtl/frame_buf_sched.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buf_sched_pkg.sv
// Shared types and constants for the triple-buffer frame scheduler.
// Holds the slot index type, the reset slot assignment and the expected-pixel helper.
package frame_buf_sched_pkg;

    typedef logic [1:0] slot_idx_t;

    localparam slot_idx_t RST_WR_SLOT  = 2'd0;
    localparam slot_idx_t RST_RD_SLOT  = 2'd1;
    localparam slot_idx_t RST_RDY_SLOT = 2'd2;

    typedef enum logic [0:0] {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } wr_state_t;

    function automatic int unsigned exp_pix_cnt(input int unsigned width, input int unsigned height);
        return width * height;
    endfunction

endpackage

// File: rtl/frame_buf_sched_if.sv
// Writer/reader handshake bundle of the frame scheduler.
// The slave modport is the scheduler side, the master modport is the client side.
interface frame_buf_sched_if #(
    parameter int ADDR_W = 32
);

    logic              i_Wr_vs;
    logic              i_Wr_de;
    logic              i_Rd_req;
    logic [ADDR_W-1:0] o_Wr_base_addr;
    logic              o_Wr_field_rst;
    logic [ADDR_W-1:0] o_Rd_base_addr;
    logic              o_Rd_ack;
    logic              o_Rd_new;

    modport slave (
        input  i_Wr_vs,
        input  i_Wr_de,
        input  i_Rd_req,
        output o_Wr_base_addr,
        output o_Wr_field_rst,
        output o_Rd_base_addr,
        output o_Rd_ack,
        output o_Rd_new
    );

    modport master (
        output i_Wr_vs,
        output i_Wr_de,
        output i_Rd_req,
        input  o_Wr_base_addr,
        input  o_Wr_field_rst,
        input  o_Rd_base_addr,
        input  o_Rd_ack,
        input  o_Rd_new
    );

endinterface

// File: rtl/frame_buf_sched.sv
// Triple-buffer scheduler: rotates three DDR base addresses between writer, reader and a ready slot,
// promoting only frames with the exact pixel count and letting the reader take the newest one.
module frame_buf_sched
    import frame_buf_sched_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int CNT_W        = 16
) (
    input  logic              i_Sys_clk,
    input  logic              i_Rst,
    input  logic [ADDR_W-1:0] i_Buffer_addr_0,
    input  logic [ADDR_W-1:0] i_Buffer_addr_1,
    input  logic [ADDR_W-1:0] i_Buffer_addr_2,
    frame_buf_sched_if.slave  bus,
    output logic [CNT_W-1:0]  o_Drop_cnt,
    output logic [CNT_W-1:0]  o_Err_cnt
);

    localparam int unsigned     PIX_EXP   = exp_pix_cnt(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int              PIX_W     = $clog2(PIX_EXP + 2);
    localparam logic [PIX_W-1:0] PIX_MATCH = PIX_W'(PIX_EXP);
    localparam logic [PIX_W-1:0] PIX_SAT   = PIX_W'(PIX_EXP + 1);

    logic              r_vs_d0;
    logic              r_vs_d1;
    logic              r_de_d0;
    wr_state_t         r_state;
    logic [PIX_W-1:0]  r_pix_cnt;
    slot_idx_t         r_wr_idx;
    slot_idx_t         r_rd_idx;
    slot_idx_t         r_rdy_idx;
    logic              r_rdy_vld;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [ADDR_W-1:0] r_wr_base;
    logic [ADDR_W-1:0] r_rd_base;
    logic              r_field_rst;
    logic              r_rd_ack;
    logic              r_rd_new;

    logic              w_rise;
    logic              w_fall;
    wr_state_t         w_state_nxt;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_frame_end;
    logic              w_frame_good;
    logic              w_frame_bad;
    slot_idx_t         w_wr_nxt;
    slot_idx_t         w_rdy_mid;
    logic              w_vld_mid;
    slot_idx_t         w_rd_nxt;
    slot_idx_t         w_rdy_nxt;
    logic              w_vld_nxt;
    logic              w_drop_inc;
    logic              w_rd_new_nxt;

    function automatic logic [ADDR_W-1:0] slot_addr(
        input slot_idx_t         idx,
        input logic [ADDR_W-1:0] addr_0,
        input logic [ADDR_W-1:0] addr_1,
        input logic [ADDR_W-1:0] addr_2
    );
        logic [ADDR_W-1:0] sel;
        case (idx)
            2'd0:    sel = addr_0;
            2'd1:    sel = addr_1;
            2'd2:    sel = addr_2;
            default: sel = addr_0;
        endcase
        return sel;
    endfunction

    // Frame-window capture; reset to "high" so a frame already running at reset is ignored
    // until the writer drops and re-raises its window.
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            r_vs_d0 <= 1'b1;
            r_vs_d1 <= 1'b1;
            r_de_d0 <= 1'b0;
        end else begin
            r_vs_d0 <= bus.i_Wr_vs;
            r_vs_d1 <= r_vs_d0;
            r_de_d0 <= bus.i_Wr_de;
        end
    end

    assign w_rise = r_vs_d0 & ~r_vs_d1;
    assign w_fall = ~r_vs_d0 & r_vs_d1;

    // Writer FSM state register.
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            r_state <= W_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Writer FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            W_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = W_ACTIVE;
                end else begin
                    w_state_nxt = W_IDLE;
                end
            end
            W_ACTIVE: begin
                if (w_fall) begin
                    w_state_nxt = W_IDLE;
                end else begin
                    w_state_nxt = W_ACTIVE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Writer FSM outputs: counter control and frame-end strobe.
    always_comb begin
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            W_IDLE: begin
                w_cnt_clr = w_rise;
            end
            W_ACTIVE: begin
                w_cnt_en    = r_vs_d0;
                w_frame_end = w_fall;
            end
            default: begin
                w_cnt_clr = 1'b0;
            end
        endcase
    end

    // Pixel counter; the rise cycle already carries a qualified pixel, so it seeds the count.
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            r_pix_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_pix_cnt <= r_de_d0 ? PIX_W'(1) : PIX_W'(0);
        end else if (w_cnt_en && r_de_d0 && (r_pix_cnt != PIX_SAT)) begin
            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
        end else begin
            r_pix_cnt <= r_pix_cnt;
        end
    end

    // Slot rotation: a good frame end is applied first, then a read request on the result.
    always_comb begin
        w_frame_good = w_frame_end && (r_pix_cnt == PIX_MATCH);
        w_frame_bad  = w_frame_end && (r_pix_cnt != PIX_MATCH);

        if (w_frame_good) begin
            w_wr_nxt   = r_rdy_idx;
            w_rdy_mid  = r_wr_idx;
            w_vld_mid  = 1'b1;
            w_drop_inc = r_rdy_vld;
        end else begin
            w_wr_nxt   = r_wr_idx;
            w_rdy_mid  = r_rdy_idx;
            w_vld_mid  = r_rdy_vld;
            w_drop_inc = 1'b0;
        end

        if (bus.i_Rd_req && w_vld_mid) begin
            w_rd_nxt     = w_rdy_mid;
            w_rdy_nxt    = r_rd_idx;
            w_vld_nxt    = 1'b0;
            w_rd_new_nxt = 1'b1;
        end else begin
            w_rd_nxt     = r_rd_idx;
            w_rdy_nxt    = w_rdy_mid;
            w_vld_nxt    = w_vld_mid;
            w_rd_new_nxt = 1'b0;
        end
    end

    // Slot indices, ready flag and statistic counters.
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            r_wr_idx   <= RST_WR_SLOT;
            r_rd_idx   <= RST_RD_SLOT;
            r_rdy_idx  <= RST_RDY_SLOT;
            r_rdy_vld  <= 1'b0;
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_wr_idx   <= w_wr_nxt;
            r_rd_idx   <= w_rd_nxt;
            r_rdy_idx  <= w_rdy_nxt;
            r_rdy_vld  <= w_vld_nxt;
            r_drop_cnt <= w_drop_inc ? (r_drop_cnt + CNT_W'(1)) : r_drop_cnt;
            r_err_cnt  <= w_frame_bad ? (r_err_cnt + CNT_W'(1)) : r_err_cnt;
        end
    end

    // Registered addresses follow the next-state indices so they move with the rotation.
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            r_wr_base   <= i_Buffer_addr_0;
            r_rd_base   <= i_Buffer_addr_1;
            r_field_rst <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_rd_new    <= 1'b0;
        end else begin
            r_wr_base   <= slot_addr(w_wr_nxt, i_Buffer_addr_0, i_Buffer_addr_1, i_Buffer_addr_2);
            r_rd_base   <= slot_addr(w_rd_nxt, i_Buffer_addr_0, i_Buffer_addr_1, i_Buffer_addr_2);
            r_field_rst <= w_cnt_clr;
            r_rd_ack    <= bus.i_Rd_req;
            r_rd_new    <= w_rd_new_nxt;
        end
    end

    assign bus.o_Wr_base_addr = r_wr_base;
    assign bus.o_Wr_field_rst = r_field_rst;
    assign bus.o_Rd_base_addr = r_rd_base;
    assign bus.o_Rd_ack       = r_rd_ack;
    assign bus.o_Rd_new       = r_rd_new;
    assign o_Drop_cnt         = r_drop_cnt;
    assign o_Err_cnt          = r_err_cnt;

endmodule
